// File: rtl/li_pkg.sv
// Shared types and helpers for the latency-insensitive channel wrappers.
// Token layout, wrapper kinds and the downstream credit-depth derivation.
package li_pkg;

    localparam int LI_DATA_WIDTH = 16;

    typedef struct packed {
        logic                     data_valid;
        logic [LI_DATA_WIDTH-1:0] data;
    } li_token_t;

    typedef enum logic [1:0] {
        NON_LI,
        CARLONI,
        CREDIT,
        QSYS
    } li_wrapper_e;

    // Downstream FIFO depth equals the number of credits a sender may hold.
    function automatic int n_credits(input int fifo_addr);
        return 1 << fifo_addr;
    endfunction

endpackage

// File: rtl/li_sync_fifo.sv
// Small synchronous FIFO with combinational head output.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module li_sync_fifo #(
    parameter int WIDTH = 17,
    parameter int ADDR  = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << ADDR;
    localparam logic [ADDR:0] DEPTH_W = (ADDR + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full     = (count_q == DEPTH_W);
    assign empty    = (count_q == '0);
    assign pop_ok   = pop & ~empty;
    assign push_ok  = push & (~full | pop_ok);
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/li_credit_arbiter.sv
// Two-requester round-robin arbiter sharing one credit-based LI channel.
// Tracks downstream credits and returns one upstream credit per popped token.
module li_credit_arbiter
    import li_pkg::*;
#(
    parameter int DATA_WIDTH   = LI_DATA_WIDTH,
    parameter int FIFO_ADDR    = 6,
    parameter int INIT_CREDITS = n_credits(FIFO_ADDR) - 1,
    parameter int RQ_ADDR      = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [1:0]              i_rq_valid,
    input  logic [1:0]              i_rq_data_valid,
    input  logic [2*DATA_WIDTH-1:0] i_rq_data_data,
    output logic [1:0]              o_rq_li_feedback,
    input  logic [1:0]              i_rq_mask,
    output logic                    o_top_valid,
    output logic                    o_top_data_valid,
    output logic [DATA_WIDTH-1:0]   o_top_data_data,
    output logic                    o_top_src,
    input  logic                    i_top_li_feedback,
    output logic [1:0]              o_overflow,
    output logic                    o_credit_err
);

    localparam int CW = FIFO_ADDR + 1;
    localparam logic [CW:0]   N_CREDITS_EXT  = (CW + 1)'(n_credits(FIFO_ADDR));
    localparam logic [CW-1:0] INIT_CREDITS_W = CW'(INIT_CREDITS);

    logic [1:0]            fifo_empty, fifo_full, elig, grant_vec, rq_drop;
    logic [DATA_WIDTH:0]   head_word [2];
    logic [DATA_WIDTH:0]   head_sel;
    logic                  grant_src, any_grant;
    logic [CW:0]           credit_sum;

    logic [CW-1:0]         credits_q, credits_d;
    logic                  last_q, last_d;
    logic                  top_valid_q, top_valid_d;
    logic                  top_dv_q, top_dv_d;
    logic [DATA_WIDTH-1:0] top_data_q, top_data_d;
    logic                  top_src_q, top_src_d;
    logic [1:0]            feedback_q, feedback_d;
    logic [1:0]            overflow_q, overflow_d;
    logic                  credit_err_q, credit_err_d;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rq
            li_sync_fifo #(
                .WIDTH (DATA_WIDTH + 1),
                .ADDR  (RQ_ADDR)
            ) u_fifo (
                .clock     (clock),
                .reset     (reset),
                .push      (i_rq_valid[gi]),
                .push_data ({i_rq_data_valid[gi], i_rq_data_data[gi*DATA_WIDTH +: DATA_WIDTH]}),
                .pop       (grant_vec[gi]),
                .pop_data  (head_word[gi]),
                .full      (fifo_full[gi]),
                .empty     (fifo_empty[gi])
            );
            assign elig[gi]    = ~fifo_empty[gi] & i_rq_mask[gi];
            assign rq_drop[gi] = i_rq_valid[gi] & fifo_full[gi] & ~grant_vec[gi];
        end
    endgenerate

    // last_q holds the most recent grant; on contention the other side wins.
    always_comb begin
        grant_vec = 2'b00;
        grant_src = last_q;
        if (credits_q != '0) begin
            case (elig)
                2'b01: begin
                    grant_vec = 2'b01;
                    grant_src = 1'b0;
                end
                2'b10: begin
                    grant_vec = 2'b10;
                    grant_src = 1'b1;
                end
                2'b11: begin
                    grant_src = ~last_q;
                    grant_vec = last_q ? 2'b01 : 2'b10;
                end
                default: grant_vec = 2'b00;
            endcase
        end
    end

    assign any_grant = |grant_vec;
    assign head_sel  = head_word[grant_src];

    always_comb begin
        top_valid_d  = any_grant;
        top_dv_d     = any_grant ? head_sel[DATA_WIDTH] : 1'b0;
        top_data_d   = any_grant ? head_sel[DATA_WIDTH-1:0] : top_data_q;
        top_src_d    = any_grant ? grant_src : top_src_q;
        last_d       = any_grant ? grant_src : last_q;
        feedback_d   = grant_vec;
        overflow_d   = overflow_q | rq_drop;
        credit_err_d = credit_err_q;
        // Sends only happen with credits_q > 0, so the sum cannot underflow.
        credit_sum   = {1'b0, credits_q} + (CW + 1)'(i_top_li_feedback) - (CW + 1)'(any_grant);
        if (credit_sum > N_CREDITS_EXT) begin
            credits_d    = N_CREDITS_EXT[CW-1:0];
            credit_err_d = 1'b1;
        end else begin
            credits_d    = credit_sum[CW-1:0];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            credits_q    <= INIT_CREDITS_W;
            last_q       <= 1'b0;
            top_valid_q  <= 1'b0;
            top_dv_q     <= 1'b0;
            top_data_q   <= '0;
            top_src_q    <= 1'b0;
            feedback_q   <= 2'b00;
            overflow_q   <= 2'b00;
            credit_err_q <= 1'b0;
        end else begin
            credits_q    <= credits_d;
            last_q       <= last_d;
            top_valid_q  <= top_valid_d;
            top_dv_q     <= top_dv_d;
            top_data_q   <= top_data_d;
            top_src_q    <= top_src_d;
            feedback_q   <= feedback_d;
            overflow_q   <= overflow_d;
            credit_err_q <= credit_err_d;
        end
    end

    assign o_top_valid      = top_valid_q;
    assign o_top_data_valid = top_dv_q;
    assign o_top_data_data  = top_data_q;
    assign o_top_src        = top_src_q;
    assign o_rq_li_feedback = feedback_q;
    assign o_overflow       = overflow_q;
    assign o_credit_err     = credit_err_q;

endmodule
